// File: rtl/adc_frame_pkg.sv
// Shared encodings for the ADC-to-UART frame scheduler: FSM states,
// default sync byte and header layout.
package adc_frame_pkg;

  typedef enum logic [1:0] {IDLE, SYNC, HDR, LSB} state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int         HDR_CH_LSB    = 6;
  localparam int         HDR_OVF_BIT   = 5;

  // Header: {channel[1:0], ovf, 3'b000, sample[9:8]}
  function automatic logic [7:0] hdr_byte(input logic [1:0] ch, input logic ovf,
                                          input logic [1:0] hi);
    logic [7:0] h;
    h = '0;
    h[HDR_CH_LSB+:2] = ch;
    h[HDR_OVF_BIT]   = ovf;
    h[1:0]           = hi;
    return h;
  endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way round-robin pick: first pending channel at or after the pointer.
module rr_arbiter4 (
  input  logic [3:0] pending,
  input  logic [1:0] pointer,
  output logic [1:0] grant,
  output logic       any_grant
);

  logic [1:0] idx;

  // Walk offsets from farthest to nearest so the nearest pending one wins.
  always_comb begin
    grant     = pointer;
    any_grant = 1'b0;
    idx       = pointer;
    for (int k = 3; k >= 0; k--) begin
      idx = pointer + 2'(k);
      if (pending[idx]) begin
        grant     = idx;
        any_grant = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adc_uart_scheduler.sv
// Captures four ADC channel samples and serialises them round-robin as
// 3-byte frames (sync, header, low byte) over a valid/ready byte port.
module adc_uart_scheduler
  import adc_frame_pkg::*;
#(
  parameter int         DATA_W    = 10,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter logic [3:0] CH_MASK   = 4'b1111
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              enable,
  input  logic [DATA_W-1:0] ch1_data,
  input  logic [DATA_W-1:0] ch2_data,
  input  logic [DATA_W-1:0] ch3_data,
  input  logic [DATA_W-1:0] ch4_data,
  input  logic [3:0]        ch_ready,
  output logic [7:0]        tx_byte,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic [15:0]       frame_count,
  output logic [3:0]        overrun,
  input  logic              overrun_clr
);

  state_t                   state;
  logic [3:0][DATA_W-1:0]   ch_data;
  logic [3:0][DATA_W-1:0]   hold;
  logic [3:0]               pending;
  logic [3:0]               ovf;
  logic [3:0]               new_ovr;
  logic [1:0]               rr_ptr;
  logic [1:0]               gnt;
  logic                     any_gnt;
  logic                     grant_now;
  logic [1:0]               g_snap;
  logic                     ovf_snap;
  logic [DATA_W-1:0]        data_snap;
  logic [1:0]               data_hi;

  assign ch_data   = {ch4_data, ch3_data, ch2_data, ch1_data};
  assign grant_now = (state == IDLE) && enable && any_gnt;
  assign busy      = (state != IDLE);
  assign data_hi   = 2'(data_snap[DATA_W-1:8]);

  rr_arbiter4 u_arb (
    .pending   (pending),
    .pointer   (rr_ptr),
    .grant     (gnt),
    .any_grant (any_gnt)
  );

  // A strobe landing on the channel being granted starts a fresh sample, not an overrun.
  always_comb begin
    new_ovr = '0;
    for (int i = 0; i < 4; i++)
      new_ovr[i] = ch_ready[i] && CH_MASK[i] && pending[i] && !(grant_now && gnt == 2'(i));
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      hold    <= '0;
      pending <= '0;
      ovf     <= '0;
      overrun <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (grant_now && gnt == 2'(i)) begin
          pending[i] <= 1'b0;
          ovf[i]     <= 1'b0;
        end
        if (ch_ready[i] && CH_MASK[i]) begin
          hold[i]    <= ch_data[i];
          pending[i] <= 1'b1;
        end
        if (new_ovr[i]) ovf[i] <= 1'b1;
      end
      overrun <= (overrun & ~{4{overrun_clr}}) | new_ovr;
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      g_snap      <= '0;
      ovf_snap    <= 1'b0;
      data_snap   <= '0;
      tx_byte     <= '0;
      tx_valid    <= 1'b0;
      frame_count <= '0;
    end else begin
      case (state)
        IDLE: if (grant_now) begin
          g_snap    <= gnt;
          ovf_snap  <= ovf[gnt];
          data_snap <= hold[gnt];
          tx_byte   <= SYNC_BYTE;
          tx_valid  <= 1'b1;
          state     <= SYNC;
        end
        SYNC: if (tx_ready) begin
          tx_byte <= hdr_byte(g_snap, ovf_snap, data_hi);
          state   <= HDR;
        end
        HDR: if (tx_ready) begin
          tx_byte <= data_snap[7:0];
          state   <= LSB;
        end
        LSB: if (tx_ready) begin
          tx_byte     <= '0;
          tx_valid    <= 1'b0;
          frame_count <= frame_count + 16'd1;
          rr_ptr      <= g_snap + 2'd1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
